// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler that shares one PISO shift register between NREQ requesters:
// it arbitrates, captures the winning word, pulses load, then times the WIDTH-cycle shift window.
module piso_tx_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 1,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         done,
  output logic                    piso_load,
  output logic [WIDTH-1:0]        piso_parallel,
  output logic                    tx_active,
  output logic [IDW-1:0]          tx_owner,
  output logic                    busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = $clog2(NREQ);
  localparam int GW = 4;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   winner;
  logic             found;
  int               idx;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] words [NREQ];
  logic             last_bit;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = data[i*WIDTH +: WIDTH];
  end

  assign last_bit = (cnt == CW'(WIDTH-1));

  // Search ascends from the requester after the last grant, wrapping at NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (found) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gcnt == GW'(GAP-1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word and owner are frozen at the IDLE->LOAD edge; later data changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      gcnt       <= '0;
      last_grant <= IDW'(NREQ-1);
      word_q     <= '0;
      tx_owner   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            word_q   <= words[IW'(winner)];
            tx_owner <= winner;
          end
        end
        S_LOAD: begin
          last_grant <= tx_owner;
          cnt        <= '0;
          gcnt       <= '0;
        end
        S_SHIFT: cnt  <= last_bit ? '0 : cnt + 1'b1;
        S_GAP:   gcnt <= gcnt + 1'b1;
        default: cnt  <= '0;
      endcase
    end
  end

  always_comb begin
    ack           = '0;
    done          = '0;
    piso_load     = 1'b0;
    piso_parallel = '0;
    tx_active     = 1'b0;
    busy          = (state != S_IDLE);
    unique case (state)
      S_LOAD: begin
        piso_load          = 1'b1;
        piso_parallel      = word_q;
        ack[IW'(tx_owner)] = 1'b1;
      end
      S_SHIFT: begin
        tx_active = 1'b1;
        if (last_bit) done[IW'(tx_owner)] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: two instances (GAP=1 and GAP=0) checked every cycle against a
// frame-timeline reference model, plus directed scenarios with hand-computed expectations.
module tb_piso_tx_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;
  localparam int DW    = NREQ*WIDTH;
  localparam int HN    = 4096;

  typedef struct {
    int               cyc;
    int               own;
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] par;
  } ld_t;
  typedef struct {
    int              cyc;
    logic [NREQ-1:0] done;
  } dn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_s  [2];
  logic [NREQ-1:0]  req_s  [2];
  logic [DW-1:0]    data_s [2];
  logic [NREQ-1:0]  ack_s  [2];
  logic [NREQ-1:0]  done_s [2];
  logic             load_s [2];
  logic [WIDTH-1:0] par_s  [2];
  logic             txa_s  [2];
  logic [IDW-1:0]   own_s  [2];
  logic             busy_s [2];

  piso_tx_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(1), .IDW(IDW)) dut0 (
    .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .data(data_s[0]),
    .ack(ack_s[0]), .done(done_s[0]), .piso_load(load_s[0]), .piso_parallel(par_s[0]),
    .tx_active(txa_s[0]), .tx_owner(own_s[0]), .busy(busy_s[0])
  );

  piso_tx_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(0), .IDW(IDW)) dut1 (
    .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .data(data_s[1]),
    .ack(ack_s[1]), .done(done_s[1]), .piso_load(load_s[1]), .piso_parallel(par_s[1]),
    .tx_active(txa_s[1]), .tx_owner(own_s[1]), .busy(busy_s[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  int               gapv [2];
  int               m_t  [2];
  int               m_lg [2];
  int               m_own[2];
  logic [WIDTH-1:0] m_word[2];

  logic busy_h [2][HN];
  logic txa_h  [2][HN];
  ld_t  ld_q0[$], ld_q1[$];
  dn_t  dn_q0[$], dn_q1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: a transfer is a timeline position m_t (0 = load, 1..WIDTH = shift,
  // then GAP idle-but-busy cycles); -1 means free to arbitrate.
  initial begin
    int  i;
    bit  hit;
    gapv[0] = 1;
    gapv[1] = 0;
    for (int d = 0; d < 2; d++) begin
      m_t[d] = -1; m_lg[d] = NREQ-1; m_own[d] = 0; m_word[d] = '0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_s[d]) begin
          m_t[d] = -1; m_lg[d] = NREQ-1; m_own[d] = 0; m_word[d] = '0;
        end else if (m_t[d] < 0) begin
          if (req_s[d] != '0) begin
            hit = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
              i = (m_lg[d] + k) % NREQ;
              if (!hit && req_s[d][i]) begin
                hit = 1'b1;
                m_own[d] = i;
              end
            end
            m_word[d] = data_s[d][m_own[d]*WIDTH +: WIDTH];
            m_t[d] = 0;
          end
        end else begin
          if (m_t[d] == 0) m_lg[d] = m_own[d];
          m_t[d]++;
          if (m_t[d] > WIDTH + gapv[d]) m_t[d] = -1;
        end
      end
    end
  end

  // Compare and log on the falling edge, away from the active edge.
  initial begin
    logic [NREQ-1:0]  oh, e_ack, e_done;
    logic [WIDTH-1:0] e_par;
    ld_t le;
    dn_t de;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (cyc < HN) begin
          busy_h[d][cyc] = busy_s[d];
          txa_h[d][cyc]  = txa_s[d];
        end
        if (load_s[d] === 1'b1) begin
          le.cyc = cyc; le.own = int'(own_s[d]); le.ack = ack_s[d]; le.par = par_s[d];
          if (d == 0) ld_q0.push_back(le); else ld_q1.push_back(le);
        end
        if (done_s[d] != '0) begin
          de.cyc = cyc; de.done = done_s[d];
          if (d == 0) dn_q0.push_back(de); else dn_q1.push_back(de);
        end
        if (chk_en) begin
          oh     = NREQ'(1) << m_own[d];
          e_ack  = (m_t[d] == 0) ? oh : {NREQ{1'b0}};
          e_done = (m_t[d] == WIDTH) ? oh : {NREQ{1'b0}};
          e_par  = (m_t[d] == 0) ? m_word[d] : {WIDTH{1'b0}};
          chk($sformatf("dut%0d outputs {ack,done,load,par,txa,busy}", d),
              64'({ack_s[d], done_s[d], load_s[d], par_s[d], txa_s[d], busy_s[d]}),
              64'({e_ack, e_done, (m_t[d] == 0), e_par,
                   (m_t[d] >= 1 && m_t[d] <= WIDTH), (m_t[d] >= 0)}));
          if (m_t[d] >= 0)
            chk($sformatf("dut%0d tx_owner", d), 64'(own_s[d]), 64'(m_own[d]));
        end
      end
    end
  end

  function automatic int nloads(input int d);
    return (d == 0) ? ld_q0.size() : ld_q1.size();
  endfunction

  task automatic wait_loads(input int d, input int target, input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (nloads(d) >= target) return;
    end
    total++; bad++;
    $display("FAIL %s: timeout, loads seen %0d expected %0d", nm, nloads(d), target);
  endtask

  task automatic wait_idle(input int d, input string nm);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (busy_s[d] == 1'b0) return;
    end
    total++; bad++;
    $display("FAIL %s: timeout waiting idle, busy stays %0b expected 0", nm, busy_s[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, nd, k0, L;
    logic [6:0] tv, bv;
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    req_s[0] = '0;   req_s[1] = '0;
    data_s[0] = '0;  data_s[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset outputs dut%0d", d),
          64'({ack_s[d], done_s[d], load_s[d], par_s[d], txa_s[d], own_s[d], busy_s[d]}), 64'(0));

    // Single word from requester 0.
    @(posedge clk); #1;
    k0 = cyc;
    data_s[0][3:0] = 4'b1101;
    req_s[0] = 4'b0001;
    n0 = ld_q0.size(); nd = dn_q0.size();
    wait_loads(0, n0+1, 20, "t1 load");
    req_s[0] = '0;
    repeat (8) @(negedge clk);
    #1;
    chk("t1 load cycle", 64'(ld_q0[n0].cyc), 64'(k0+1));
    chk("t1 parallel", 64'(ld_q0[n0].par), 64'(4'b1101));
    chk("t1 ack", 64'(ld_q0[n0].ack), 64'(4'b0001));
    chk("t1 done cycle", 64'(dn_q0[nd].cyc), 64'(k0+5));
    chk("t1 done", 64'(dn_q0[nd].done), 64'(4'b0001));
    for (int j = 0; j < 7; j++) begin
      tv[6-j] = txa_h[0][k0+1+j];
      bv[6-j] = busy_h[0][k0+1+j];
    end
    chk("t1 tx_active window", 64'(tv), 64'(7'b0111100));
    chk("t1 busy window", 64'(bv), 64'(7'b1111110));

    // All four requesting after a fresh reset.
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    data_s[0] = DW'($urandom);
    n0 = ld_q0.size();
    req_s[0] = 4'b1111;
    wait_loads(0, n0+5, 60, "t2 loads");
    req_s[0] = '0;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("t2 owner #%0d", j), 64'(ld_q0[n0+j].own), 64'(j % 4));
      chk($sformatf("t2 ack #%0d", j), 64'(ld_q0[n0+j].ack), 64'(4'b0001 << (j % 4)));
      if (j > 0)
        chk($sformatf("t2 load spacing #%0d", j),
            64'(ld_q0[n0+j].cyc - ld_q0[n0+j-1].cyc), 64'(7));
    end
    wait_idle(0, "t2 idle");

    // Wrap past the top: last grant 2, then 0 and 2 request.
    n0 = ld_q0.size();
    req_s[0] = 4'b0100;
    wait_loads(0, n0+1, 20, "t3 first");
    req_s[0] = 4'b0101;
    wait_loads(0, n0+3, 30, "t3 next");
    req_s[0] = '0;
    chk("t3 owner a", 64'(ld_q0[n0].own), 64'(2));
    chk("t3 owner b", 64'(ld_q0[n0+1].own), 64'(0));
    chk("t3 owner c", 64'(ld_q0[n0+2].own), 64'(2));
    wait_idle(0, "t3 idle");

    // Data changes during SHIFT must not disturb the word in flight.
    n0 = ld_q0.size();
    data_s[0][7:4] = 4'b0110;
    req_s[0] = 4'b0010;
    wait_loads(0, n0+1, 20, "t4 first");
    @(negedge clk); #1;
    @(negedge clk); #1;
    data_s[0][7:4] = 4'b1001;
    wait_loads(0, n0+2, 20, "t4 second");
    req_s[0] = '0;
    chk("t4 parallel first", 64'(ld_q0[n0].par), 64'(4'b0110));
    chk("t4 parallel second", 64'(ld_q0[n0+1].par), 64'(4'b1001));
    wait_idle(0, "t4 idle");

    // Reset in the 2nd SHIFT cycle aborts without done and restores priority to requester 0.
    n0 = ld_q0.size();
    req_s[0] = 4'b0001;
    wait_loads(0, n0+1, 20, "t5 load");
    L = cyc;
    req_s[0] = '0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_s[0] = 1'b1;
    req_s[0] = 4'b0011;
    n0 = ld_q0.size(); nd = dn_q0.size();
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    @(negedge clk); #1;
    chk("t5 outputs after reset",
        64'({ack_s[0], done_s[0], load_s[0], par_s[0], txa_s[0], own_s[0], busy_s[0]}), 64'(0));
    wait_loads(0, n0+1, 20, "t5 reload");
    req_s[0] = '0;
    chk("t5 owner after reset", 64'(ld_q0[n0].own), 64'(0));
    chk("t5 reload cycle", 64'(ld_q0[n0].cyc), 64'(L+4));
    wait_idle(0, "t5 idle");
    chk("t5 first done cycle after reset", 64'(dn_q0[nd].cyc), 64'(L+8));
    chk("t5 first done after reset", 64'(dn_q0[nd].done), 64'(4'b0001));

    // GAP=0 instance: 6-cycle period with one idle cycle between words.
    n1 = ld_q1.size();
    data_s[1] = DW'($urandom);
    req_s[1] = 4'b0011;
    wait_loads(1, n1+4, 40, "t6 loads");
    req_s[1] = '0;
    for (int j = 0; j < 4; j++)
      chk($sformatf("t6 owner #%0d", j), 64'(ld_q1[n1+j].own), 64'(j % 2));
    for (int j = 1; j < 4; j++) begin
      chk($sformatf("t6 spacing #%0d", j), 64'(ld_q1[n1+j].cyc - ld_q1[n1+j-1].cyc), 64'(6));
      chk($sformatf("t6 idle gap #%0d", j), 64'(busy_h[1][ld_q1[n1+j].cyc-1]), 64'(0));
      chk($sformatf("t6 busy before gap #%0d", j), 64'(busy_h[1][ld_q1[n1+j].cyc-2]), 64'(1));
    end
    wait_idle(1, "t6 idle");

    // Randomized traffic with occasional resets on both instances.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 3) == 0) req_s[d] = NREQ'($urandom);
        if ($urandom_range(0, 3) == 0) data_s[d] = DW'($urandom);
        rst_s[d] = ($urandom_range(0, 299) == 0);
      end
    end
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    req_s[0] = '0;   req_s[1] = '0;
    repeat (10) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
